// File: rtl/axil_mcl_fifo_bridge_pkg.sv
// Shared definitions for the AXI-Lite <-> MCL FIFO bridge.
//   - register offsets within the 0x100-byte window (decoded on addr[7:0])
//   - AXI-Lite response encodings
//   - write / read channel FSM state types
//   - byte-strobe merge helper for the RW packet words
package axil_mcl_fifo_bridge_pkg;

  localparam logic [7:0] RegTxW0   = 8'h00;
  localparam logic [7:0] RegTxW1   = 8'h04;
  localparam logic [7:0] RegTxW2   = 8'h08;
  localparam logic [7:0] RegTxVac  = 8'h0C;
  localparam logic [7:0] RegRxW0   = 8'h10;
  localparam logic [7:0] RegRxW1   = 8'h14;
  localparam logic [7:0] RegRxW2   = 8'h18;
  localparam logic [7:0] RegRxOcc  = 8'h1C;
  localparam logic [7:0] RegStatus = 8'h20;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;

  typedef enum logic {WIdle, WResp} w_state_e;
  typedef enum logic {RIdle, RResp} r_state_e;

  // Replace only the bytes whose strobe is set.
  function automatic logic [31:0] apply_wstrb(logic [31:0] old_word, logic [31:0] new_word,
                                              logic [3:0] strb);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = strb[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/bsg_fifo_1r1w_small.sv
// Small one-read/one-write FIFO with registered storage.
// Ports:
//   clk_i, reset_i      clock, asynchronous active-high reset
//   v_i / ready_o       enqueue handshake; ready_o is "not full" before any dequeue
//   data_i              enqueue data
//   v_o / data_o        head valid and head data
//   yumi_i              dequeue the head (only meaningful while v_o)
//   count_o             current occupancy
module bsg_fifo_1r1w_small #(
  parameter int width_p = 80,
  parameter int els_p   = 4
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   v_i,
  output logic                   ready_o,
  input  logic [width_p-1:0]     data_i,
  output logic                   v_o,
  output logic [width_p-1:0]     data_o,
  input  logic                   yumi_i,
  output logic [$clog2(els_p):0] count_o
);

  localparam int PtrW = $clog2(els_p);
  localparam int CntW = PtrW + 1;

  if (els_p < 2 || (els_p & (els_p - 1)) != 0) begin : g_bad_els
    $fatal(1, "bsg_fifo_1r1w_small: els_p must be a power of two and at least 2");
  end

  logic [width_p-1:0] mem_q [els_p];
  logic [PtrW-1:0]    rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0]    count_q, count_d;
  logic               enq, deq;

  assign ready_o = (count_q != CntW'(els_p));
  assign v_o     = (count_q != '0);
  assign enq     = v_i && ready_o;
  assign deq     = yumi_i && v_o;
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_comb begin
    count_d = count_q;
    case ({enq, deq})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Depth is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (enq) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (deq) rd_ptr_q <= rd_ptr_q + PtrW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/axil_mcl_fifo_bridge.sv
// AXI-Lite slave that packs 32-bit register writes into 80-bit MCL packets (TX FIFO)
// and unpacks received MCL packets for 32-bit register reads (RX FIFO).
// Ports:
//   clk_i, reset_n_i          clock, asynchronous active-low reset
//   s_axil_aw* / w* / b*      AXI-Lite write channels (addr[7:0] decoded)
//   s_axil_ar* / r*           AXI-Lite read channels (addr[7:0] decoded)
//   mcl_v_i/mcl_data_i        inbound packet, consumed when mcl_yumi_o
//   mcl_v_o/mcl_data_o        outbound packet (TX head), taken when mcl_ready_i
module axil_mcl_fifo_bridge
  import axil_mcl_fifo_bridge_pkg::*;
#(
  parameter int mcl_width_p = 80,
  parameter int fifo_els_p  = 4
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic [31:0]            s_axil_awaddr,
  input  logic                   s_axil_awvalid,
  output logic                   s_axil_awready,
  input  logic [31:0]            s_axil_wdata,
  input  logic [3:0]             s_axil_wstrb,
  input  logic                   s_axil_wvalid,
  output logic                   s_axil_wready,
  output logic [1:0]             s_axil_bresp,
  output logic                   s_axil_bvalid,
  input  logic                   s_axil_bready,
  input  logic [31:0]            s_axil_araddr,
  input  logic                   s_axil_arvalid,
  output logic                   s_axil_arready,
  output logic [31:0]            s_axil_rdata,
  output logic [1:0]             s_axil_rresp,
  output logic                   s_axil_rvalid,
  input  logic                   s_axil_rready,
  input  logic                   mcl_v_i,
  input  logic [mcl_width_p-1:0] mcl_data_i,
  output logic                   mcl_yumi_o,
  output logic                   mcl_v_o,
  output logic [mcl_width_p-1:0] mcl_data_o,
  input  logic                   mcl_ready_i
);

  localparam int CntW = $clog2(fifo_els_p) + 1;

  if (mcl_width_p != 80) begin : g_bad_width
    $fatal(1, "axil_mcl_fifo_bridge: mcl_width_p must be 80");
  end

  w_state_e w_state_q, w_state_d;
  r_state_e r_state_q, r_state_d;

  logic        rdy_q;  // holds the ready outputs low until the first edge after reset
  logic        aw_held_q, w_held_q;
  logic [7:0]  awaddr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic [31:0] tx_w0_q, tx_w1_q;
  logic        tx_ovf_q, rx_unf_q;
  logic [1:0]  bresp_q, rresp_q;
  logic [31:0] rdata_q;

  logic        aw_hs, w_hs, ar_hs, wr_fire;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;
  logic [1:0]  wr_resp, rd_resp, clr_status;
  logic [31:0] rd_data;
  logic        tx_enq, set_tx_ovf, rx_pop, set_rx_unf;

  logic                   fifo_reset;
  logic                   tx_ready, tx_v, rx_ready, rx_v;
  logic [mcl_width_p-1:0] tx_data, rx_data;
  logic [CntW-1:0]        tx_count, rx_count, tx_vac;
  logic                   unused_bits;

  assign unused_bits = ^{s_axil_awaddr[31:8], s_axil_araddr[31:8]};

  // ---------------- FSMs: state register / next state / outputs ----------------
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      w_state_q <= WIdle;
      r_state_q <= RIdle;
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
    end
  end

  always_comb begin
    w_state_d = w_state_q;
    r_state_d = r_state_q;
    unique case (w_state_q)
      WIdle:   if (wr_fire) w_state_d = WResp;
      WResp:   if (s_axil_bready) w_state_d = WIdle;
      default: w_state_d = WIdle;
    endcase
    unique case (r_state_q)
      RIdle:   if (ar_hs) r_state_d = RResp;
      RResp:   if (s_axil_rready) r_state_d = RIdle;
      default: r_state_d = RIdle;
    endcase
  end

  // Once a channel is latched its ready drops so a second beat cannot overwrite it.
  always_comb begin
    s_axil_awready = 1'b0;
    s_axil_wready  = 1'b0;
    s_axil_bvalid  = 1'b0;
    s_axil_arready = 1'b0;
    s_axil_rvalid  = 1'b0;
    unique case (w_state_q)
      WIdle: begin
        s_axil_awready = rdy_q && !aw_held_q;
        s_axil_wready  = rdy_q && !w_held_q;
      end
      WResp:   s_axil_bvalid = 1'b1;
      default: ;
    endcase
    unique case (r_state_q)
      RIdle:   s_axil_arready = rdy_q;
      RResp:   s_axil_rvalid  = 1'b1;
      default: ;
    endcase
  end

  // ---------------- write channel ----------------
  assign aw_hs   = s_axil_awvalid && s_axil_awready;
  assign w_hs    = s_axil_wvalid && s_axil_wready;
  assign wr_fire = (aw_held_q || aw_hs) && (w_held_q || w_hs);
  assign wr_addr = aw_held_q ? awaddr_q : s_axil_awaddr[7:0];
  assign wr_data = w_held_q ? wdata_q : s_axil_wdata;
  assign wr_strb = w_held_q ? wstrb_q : s_axil_wstrb;

  always_comb begin
    wr_resp    = RespOkay;
    tx_enq     = 1'b0;
    set_tx_ovf = 1'b0;
    clr_status = 2'b00;
    if (wr_fire) begin
      case (wr_addr)
        RegTxW0, RegTxW1, RegTxVac, RegRxW0, RegRxW1, RegRxW2, RegRxOcc: ;
        RegTxW2: begin
          if (tx_ready) begin
            tx_enq = 1'b1;
          end else begin
            set_tx_ovf = 1'b1;
            wr_resp    = RespSlvErr;
          end
        end
        RegStatus: clr_status = wr_data[1:0];
        default:   wr_resp = RespSlvErr;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rdy_q     <= 1'b0;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      tx_w0_q   <= '0;
      tx_w1_q   <= '0;
      tx_ovf_q  <= 1'b0;
      rx_unf_q  <= 1'b0;
      bresp_q   <= RespOkay;
      rdata_q   <= '0;
      rresp_q   <= RespOkay;
    end else begin
      rdy_q <= 1'b1;
      if (wr_fire) begin
        aw_held_q <= 1'b0;
        w_held_q  <= 1'b0;
        bresp_q   <= wr_resp;
        if (wr_addr == RegTxW0) tx_w0_q <= apply_wstrb(tx_w0_q, wr_data, wr_strb);
        if (wr_addr == RegTxW1) tx_w1_q <= apply_wstrb(tx_w1_q, wr_data, wr_strb);
      end else begin
        if (aw_hs) begin
          aw_held_q <= 1'b1;
          awaddr_q  <= s_axil_awaddr[7:0];
        end
        if (w_hs) begin
          w_held_q <= 1'b1;
          wdata_q  <= s_axil_wdata;
          wstrb_q  <= s_axil_wstrb;
        end
      end
      // A new error in the same cycle as its clear keeps the bit set.
      tx_ovf_q <= set_tx_ovf | (tx_ovf_q & ~clr_status[0]);
      rx_unf_q <= set_rx_unf | (rx_unf_q & ~clr_status[1]);
      if (ar_hs) begin
        rdata_q <= rd_data;
        rresp_q <= rd_resp;
      end
    end
  end

  // ---------------- read channel ----------------
  assign ar_hs  = s_axil_arvalid && s_axil_arready;
  assign tx_vac = CntW'(fifo_els_p) - tx_count;

  always_comb begin
    rd_data    = '0;
    rd_resp    = RespOkay;
    rx_pop     = 1'b0;
    set_rx_unf = 1'b0;
    case (s_axil_araddr[7:0])
      RegTxW0:  rd_data = tx_w0_q;
      RegTxW1:  rd_data = tx_w1_q;
      RegTxW2:  ;
      RegTxVac: rd_data = 32'(tx_vac);
      RegRxW0, RegRxW1, RegRxW2: begin
        if (!rx_v) begin
          rd_resp    = RespSlvErr;
          set_rx_unf = ar_hs;
        end else if (s_axil_araddr[7:0] == RegRxW0) begin
          rd_data = rx_data[31:0];
        end else if (s_axil_araddr[7:0] == RegRxW1) begin
          rd_data = rx_data[63:32];
        end else begin
          rd_data = {16'h0000, rx_data[79:64]};
          rx_pop  = ar_hs;
        end
      end
      RegRxOcc:  rd_data = 32'(rx_count);
      RegStatus: rd_data = {30'd0, rx_unf_q, tx_ovf_q};
      default:   rd_resp = RespSlvErr;
    endcase
  end

  assign s_axil_bresp = bresp_q;
  assign s_axil_rdata = rdata_q;
  assign s_axil_rresp = rresp_q;

  // ---------------- FIFOs ----------------
  assign fifo_reset = ~reset_n_i;
  assign mcl_yumi_o = mcl_v_i && rx_ready && rdy_q;
  assign mcl_v_o    = tx_v;
  assign mcl_data_o = tx_v ? tx_data : '0;

  bsg_fifo_1r1w_small #(
    .width_p(mcl_width_p),
    .els_p  (fifo_els_p)
  ) u_tx_fifo (
    .clk_i  (clk_i),
    .reset_i(fifo_reset),
    .v_i    (tx_enq),
    .ready_o(tx_ready),
    .data_i ({wr_data[15:0], tx_w1_q, tx_w0_q}),
    .v_o    (tx_v),
    .data_o (tx_data),
    .yumi_i (tx_v && mcl_ready_i),
    .count_o(tx_count)
  );

  bsg_fifo_1r1w_small #(
    .width_p(mcl_width_p),
    .els_p  (fifo_els_p)
  ) u_rx_fifo (
    .clk_i  (clk_i),
    .reset_i(fifo_reset),
    .v_i    (mcl_yumi_o),
    .ready_o(rx_ready),
    .data_i (mcl_data_i),
    .v_o    (rx_v),
    .data_o (rx_data),
    .yumi_i (rx_pop),
    .count_o(rx_count)
  );

endmodule

// File: tb/tb_axil_mcl_fifo_bridge.sv
module tb_axil_mcl_fifo_bridge;

  localparam int Els = 4;

  logic        clk_i = 1'b0;
  logic        reset_n_i = 1'b0;
  logic [31:0] s_axil_awaddr = '0;
  logic        s_axil_awvalid = 1'b0;
  logic        s_axil_awready;
  logic [31:0] s_axil_wdata = '0;
  logic [3:0]  s_axil_wstrb = '0;
  logic        s_axil_wvalid = 1'b0;
  logic        s_axil_wready;
  logic [1:0]  s_axil_bresp;
  logic        s_axil_bvalid;
  logic        s_axil_bready = 1'b0;
  logic [31:0] s_axil_araddr = '0;
  logic        s_axil_arvalid = 1'b0;
  logic        s_axil_arready;
  logic [31:0] s_axil_rdata;
  logic [1:0]  s_axil_rresp;
  logic        s_axil_rvalid;
  logic        s_axil_rready = 1'b0;
  logic        mcl_v_i = 1'b0;
  logic [79:0] mcl_data_i = '0;
  logic        mcl_yumi_o;
  logic        mcl_v_o;
  logic [79:0] mcl_data_o;
  logic        mcl_ready_i = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  axil_mcl_fifo_bridge #(
    .mcl_width_p(80),
    .fifo_els_p (Els)
  ) dut (
    .clk_i         (clk_i),
    .reset_n_i     (reset_n_i),
    .s_axil_awaddr (s_axil_awaddr),
    .s_axil_awvalid(s_axil_awvalid),
    .s_axil_awready(s_axil_awready),
    .s_axil_wdata  (s_axil_wdata),
    .s_axil_wstrb  (s_axil_wstrb),
    .s_axil_wvalid (s_axil_wvalid),
    .s_axil_wready (s_axil_wready),
    .s_axil_bresp  (s_axil_bresp),
    .s_axil_bvalid (s_axil_bvalid),
    .s_axil_bready (s_axil_bready),
    .s_axil_araddr (s_axil_araddr),
    .s_axil_arvalid(s_axil_arvalid),
    .s_axil_arready(s_axil_arready),
    .s_axil_rdata  (s_axil_rdata),
    .s_axil_rresp  (s_axil_rresp),
    .s_axil_rvalid (s_axil_rvalid),
    .s_axil_rready (s_axil_rready),
    .mcl_v_i       (mcl_v_i),
    .mcl_data_i    (mcl_data_i),
    .mcl_yumi_o    (mcl_yumi_o),
    .mcl_v_o       (mcl_v_o),
    .mcl_data_o    (mcl_data_o),
    .mcl_ready_i   (mcl_ready_i)
  );

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=timeout required=handshake", name);
  endtask

  function automatic logic [31:0] merge(logic [31:0] old_w, logic [31:0] new_w, logic [3:0] s);
    logic [31:0] mask;
    mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    return (old_w & ~mask) | (new_w & mask);
  endfunction

  // ---------------- reference model (queues + register values) ----------------
  logic [79:0] m_tx[$];
  logic [79:0] m_rx[$];
  logic [1:0]  exp_b[$];
  logic [33:0] exp_r[$];
  logic [31:0] m_w0, m_w1, m_wdata;
  logic [7:0]  m_awaddr;
  logic [3:0]  m_wstrb;
  bit          m_ovf, m_unf, m_aw_seen, m_w_seen;
  int          tx_seen_cnt = 0;
  logic [79:0] tx_seen_data = '0;

  always @(negedge clk_i) begin : model
    logic [31:0] rd;
    logic [1:0]  rr, br, w1c;
    bit          pop_rx, push_tx, set_ovf, set_unf, pop_tx, push_rx;
    logic [79:0] pkt;
    if (!reset_n_i) begin
      m_tx.delete(); m_rx.delete(); exp_b.delete(); exp_r.delete();
      m_w0 = '0; m_w1 = '0; m_ovf = 0; m_unf = 0; m_aw_seen = 0; m_w_seen = 0;
    end else begin
      chk("mcl_v_o", {79'd0, mcl_v_o}, {79'd0, m_tx.size() != 0});
      if (m_tx.size() != 0) chk("mcl_data_o", mcl_data_o, m_tx[0]);
      chk("mcl_yumi_o", {79'd0, mcl_yumi_o}, {79'd0, mcl_v_i && m_rx.size() < Els});
      if (mcl_v_o) begin
        tx_seen_cnt++;
        tx_seen_data = mcl_data_o;
      end
      if (s_axil_bvalid && s_axil_bready) begin
        if (exp_b.size() == 0) chk("b_unexpected", 80'(s_axil_bresp), 80'h3ff);
        else chk("bresp_model", 80'(s_axil_bresp), 80'(exp_b.pop_front()));
      end
      if (s_axil_rvalid && s_axil_rready) begin
        if (exp_r.size() == 0) chk("r_unexpected", 80'(s_axil_rdata), 80'h3ff);
        else chk("rresp_rdata_model", 80'({s_axil_rresp, s_axil_rdata}), 80'(exp_r.pop_front()));
      end
      pop_rx = 0; push_tx = 0; set_ovf = 0; set_unf = 0; w1c = 2'b00; pkt = '0;
      // Reads see state before this edge's updates.
      if (s_axil_arvalid && s_axil_arready) begin
        rd = '0; rr = 2'b00;
        case (s_axil_araddr[7:0])
          8'h00: rd = m_w0;
          8'h04: rd = m_w1;
          8'h0C: rd = 32'(Els - m_tx.size());
          8'h10, 8'h14, 8'h18: begin
            if (m_rx.size() == 0) begin
              rr = 2'b10; set_unf = 1;
            end else if (s_axil_araddr[7:0] == 8'h10) rd = m_rx[0][31:0];
            else if (s_axil_araddr[7:0] == 8'h14) rd = m_rx[0][63:32];
            else begin
              rd = {16'h0, m_rx[0][79:64]}; pop_rx = 1;
            end
          end
          8'h1C: rd = 32'(m_rx.size());
          8'h20: rd = {30'd0, m_unf, m_ovf};
          8'h08: rd = '0;
          default: rr = 2'b10;
        endcase
        exp_r.push_back({rr, rd});
      end
      if (s_axil_awvalid && s_axil_awready) begin
        m_aw_seen = 1; m_awaddr = s_axil_awaddr[7:0];
      end
      if (s_axil_wvalid && s_axil_wready) begin
        m_w_seen = 1; m_wdata = s_axil_wdata; m_wstrb = s_axil_wstrb;
      end
      if (m_aw_seen && m_w_seen) begin
        br = 2'b00;
        case (m_awaddr)
          8'h00: m_w0 = merge(m_w0, m_wdata, m_wstrb);
          8'h04: m_w1 = merge(m_w1, m_wdata, m_wstrb);
          8'h08: begin
            if (m_tx.size() < Els) begin
              push_tx = 1; pkt = {m_wdata[15:0], m_w1, m_w0};
            end else begin
              set_ovf = 1; br = 2'b10;
            end
          end
          8'h0C, 8'h10, 8'h14, 8'h18, 8'h1C: ;
          8'h20: w1c = m_wdata[1:0];
          default: br = 2'b10;
        endcase
        exp_b.push_back(br);
        m_aw_seen = 0; m_w_seen = 0;
      end
      pop_tx  = (m_tx.size() != 0) && mcl_ready_i;
      push_rx = mcl_v_i && (m_rx.size() < Els);
      if (pop_tx) void'(m_tx.pop_front());
      if (push_tx) m_tx.push_back(pkt);
      if (pop_rx) void'(m_rx.pop_front());
      if (push_rx) m_rx.push_back(mcl_data_i);
      m_ovf = set_ovf | (m_ovf & ~w1c[0]);
      m_unf = set_unf | (m_unf & ~w1c[1]);
    end
  end

  // ---------------- bus tasks (called at posedge + 1) ----------------
  task automatic axi_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int w_lead, input int b_hold, output logic [1:0] resp);
    int  n;
    bit  aw_done, w_done, awh, wh, got;
    s_axil_awaddr = {24'h0, addr};
    s_axil_wdata = data; s_axil_wstrb = strb; s_axil_wvalid = 1'b1;
    s_axil_awvalid = (w_lead == 0);
    aw_done = 0; w_done = 0; n = 0; resp = 2'b11;
    while (!(aw_done && w_done) && n < 50) begin
      @(negedge clk_i);
      awh = s_axil_awvalid && s_axil_awready;
      wh  = s_axil_wvalid && s_axil_wready;
      @(posedge clk_i); #1;
      if (awh) begin aw_done = 1; s_axil_awvalid = 1'b0; end
      if (wh) begin w_done = 1; s_axil_wvalid = 1'b0; end
      n++;
      if (!aw_done && n >= w_lead) s_axil_awvalid = 1'b1;
    end
    s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
    if (!(aw_done && w_done)) begin
      timeout_fail("write_addr_data");
      return;
    end
    for (int i = 0; i < b_hold; i++) begin
      @(negedge clk_i);
      chk("b_hold_bvalid", {79'd0, s_axil_bvalid}, 80'd1);
      chk("b_hold_awready", {79'd0, s_axil_awready}, 80'd0);
      chk("b_hold_wready", {79'd0, s_axil_wready}, 80'd0);
      @(posedge clk_i); #1;
    end
    s_axil_bready = 1'b1; got = 0; n = 0;
    while (!got && n < 50) begin
      @(negedge clk_i);
      if (s_axil_bvalid) begin got = 1; resp = s_axil_bresp; end
      @(posedge clk_i); #1;
      n++;
    end
    s_axil_bready = 1'b0;
    if (!got) timeout_fail("write_bresp");
  endtask

  task automatic axi_read(input logic [7:0] addr, output logic [31:0] data,
                          output logic [1:0] resp);
    int n;
    bit got;
    s_axil_araddr = {24'h0, addr}; s_axil_arvalid = 1'b1;
    data = '1; resp = 2'b11; got = 0; n = 0;
    while (!got && n < 50) begin
      @(negedge clk_i);
      got = s_axil_arready;
      @(posedge clk_i); #1;
      n++;
    end
    s_axil_arvalid = 1'b0;
    if (!got) begin
      timeout_fail("read_addr");
      return;
    end
    s_axil_rready = 1'b1; got = 0; n = 0;
    while (!got && n < 50) begin
      @(negedge clk_i);
      if (s_axil_rvalid) begin got = 1; data = s_axil_rdata; resp = s_axil_rresp; end
      @(posedge clk_i); #1;
      n++;
    end
    s_axil_rready = 1'b0;
    if (!got) timeout_fail("read_data");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin : stim
    logic [1:0]  resp;
    logic [31:0] rd;
    repeat (3) @(posedge clk_i);
    #1 reset_n_i = 1'b1;
    chk("rst_awready", {79'd0, s_axil_awready}, 80'd0);
    chk("rst_arready", {79'd0, s_axil_arready}, 80'd0);
    chk("rst_outputs", {s_axil_bvalid, s_axil_rvalid, mcl_v_o, s_axil_rdata}, 80'd0);
    @(posedge clk_i); #1;
    chk("post_rst_readies", {77'd0, s_axil_awready, s_axil_wready, s_axil_arready}, 80'd7);

    // Single packet straight through
    mcl_ready_i = 1'b1;
    tx_seen_cnt = 0;
    axi_write(8'h00, 32'h11111111, 4'hF, 0, 0, resp); chk("t1_bresp_w0", 80'(resp), 80'd0);
    axi_write(8'h04, 32'h22222222, 4'hF, 0, 0, resp); chk("t1_bresp_w1", 80'(resp), 80'd0);
    axi_write(8'h08, 32'h0000ABCD, 4'hF, 0, 0, resp); chk("t1_bresp_w2", 80'(resp), 80'd0);
    repeat (3) @(posedge clk_i); #1;
    chk("t1_tx_cycles", 80'(tx_seen_cnt), 80'd1);
    chk("t1_tx_data", tx_seen_data, 80'hABCD_22222222_11111111);

    // TX overflow
    mcl_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      axi_write(8'h08, 32'(i), 4'hF, 0, 0, resp);
      chk("t2_bresp", 80'(resp), (i == 4) ? 80'd2 : 80'd0);
    end
    axi_read(8'h0C, rd, resp); chk("t2_tx_vac_full", 80'(rd), 80'd0);
    axi_read(8'h20, rd, resp); chk("t2_status_ovf", 80'(rd), 80'd1);
    axi_write(8'h20, 32'h1, 4'hF, 0, 0, resp); chk("t2_w1c_bresp", 80'(resp), 80'd0);
    axi_read(8'h20, rd, resp); chk("t2_status_clr", 80'(rd), 80'd0);
    mcl_ready_i = 1'b1;
    repeat (6) @(posedge clk_i); #1;
    mcl_ready_i = 1'b0;
    axi_read(8'h0C, rd, resp); chk("t2_tx_vac_drained", 80'(rd), 80'd4);

    // RX packet readback
    mcl_data_i = 80'h0123_456789AB_CDEF0123; mcl_v_i = 1'b1;
    @(posedge clk_i); #1;
    mcl_v_i = 1'b0;
    axi_read(8'h1C, rd, resp); chk("t3_rx_occ1", 80'(rd), 80'd1);
    axi_read(8'h10, rd, resp); chk("t3_rx_w0", 80'({resp, rd}), 80'h0_CDEF0123);
    axi_read(8'h14, rd, resp); chk("t3_rx_w1", 80'({resp, rd}), 80'h0_456789AB);
    axi_read(8'h18, rd, resp); chk("t3_rx_w2", 80'({resp, rd}), 80'h0_00000123);
    axi_read(8'h1C, rd, resp); chk("t3_rx_occ0", 80'(rd), 80'd0);

    // RX underflow
    axi_read(8'h18, rd, resp); chk("t4_unf_rdata", 80'(rd), 80'd0);
    chk("t4_unf_rresp", 80'(resp), 80'd2);
    axi_read(8'h20, rd, resp); chk("t4_status_unf", 80'(rd), 80'd2);
    mcl_v_i = 1'b1; #1;
    chk("t4_yumi_hi", {79'd0, mcl_yumi_o}, 80'd1);
    mcl_v_i = 1'b0; #1;
    chk("t4_yumi_lo", {79'd0, mcl_yumi_o}, 80'd0);
    @(posedge clk_i); #1;
    axi_write(8'h20, 32'h2, 4'hF, 0, 0, resp);
    axi_read(8'h44, rd, resp); chk("t4_bad_addr", 80'({resp, rd}), 80'h2_00000000);

    // W before AW, long B stall, byte strobe
    axi_write(8'h00, 32'hAAAAAA55, 4'b0001, 3, 5, resp); chk("t5_bresp", 80'(resp), 80'd0);
    axi_read(8'h00, rd, resp); chk("t5_strobe", 80'(rd), 80'h11111155);

    // Reset mid-write with two queued packets
    axi_write(8'h08, 32'h1, 4'hF, 0, 0, resp);
    axi_write(8'h08, 32'h2, 4'hF, 0, 0, resp);
    s_axil_awaddr = 32'h0; s_axil_awvalid = 1'b1;
    @(posedge clk_i); #1;
    s_axil_awvalid = 1'b0;
    #1 reset_n_i = 1'b0;
    #1;
    chk("t6_mcl_v_rst", {79'd0, mcl_v_o}, 80'd0);
    chk("t6_awready_rst", {79'd0, s_axil_awready}, 80'd0);
    @(posedge clk_i); #1;
    reset_n_i = 1'b1;
    @(posedge clk_i); #1;
    axi_read(8'h0C, rd, resp); chk("t6_tx_vac", 80'(rd), 80'd4);
    axi_read(8'h20, rd, resp); chk("t6_status", 80'(rd), 80'd0);
    axi_read(8'h00, rd, resp); chk("t6_tx_w0_clr", 80'(rd), 80'd0);

    repeat (2) @(posedge clk_i);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
